// File: rtl/avm_note_writer.sv
`default_nettype none
// ============================================================================
// Module      : avm_note_writer
// Description : Turns note-on / note-off events into Avalon-MM register
//               writes for a 4-voice synth (FREQ, AMP1, AMP0, KEY).
//               Optional KEY readback check enabled by defining the macro
//               AVM_NOTE_WRITER_READBACK_EN (adds RD_KEY state and ERR flag).
// Revision    : 1.0 - initial release
// ============================================================================
module avm_note_writer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EV_VALID,
  output logic        EV_READY,
  input  logic        EV_ON,
  input  logic [1:0]  EV_VOICE,
  input  logic [6:0]  EV_NOTE,
  input  logic [15:0] EV_AMP1,
  input  logic [15:0] EV_AMP0,
  output logic [5:0]  AVM_ADDR,
  output logic        AVM_WRITE,
  output logic        AVM_READ,
  output logic        AVM_CS,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  output logic        BUSY,
  output logic [15:0] EV_COUNT,
  output logic        ERR,
  input  logic        CLR_ERR
);

`ifdef AVM_NOTE_WRITER_READBACK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_FREQ = 3'd1,
    W_AMP1 = 3'd2,
    W_AMP0 = 3'd3,
    W_KEY  = 3'd4,
    RD_KEY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_FREQ = 3'd1,
    W_AMP1 = 3'd2,
    W_AMP0 = 3'd3,
    W_KEY  = 3'd4
  } state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        ev_on;
  logic [1:0]  voice;
  logic [6:0]  note;
  logic [15:0] amp1;
  logic [15:0] amp0;
  logic [15:0] ev_cnt;
  logic        accept;
  logic        done;

  assign accept   = EV_VALID && (state == IDLE);
  assign EV_READY = (state == IDLE);
  assign BUSY     = (state != IDLE);
  assign EV_COUNT = ev_cnt;

  // State register; reset drops any event in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture the whole event on the accepting edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ev_on <= 1'b0;
      voice <= 2'd0;
      note  <= 7'd0;
      amp1  <= 16'd0;
      amp0  <= 16'd0;
    end else if (accept) begin
      ev_on <= EV_ON;
      voice <= EV_VOICE;
      note  <= EV_NOTE;
      amp1  <= EV_AMP1;
      amp0  <= EV_AMP0;
    end
  end

  // Next state and bus drive; address/data depend only on state and captured fields
  always_comb begin
    state_nxt     = state;
    AVM_WRITE     = 1'b0;
    AVM_READ      = 1'b0;
    AVM_CS        = 1'b0;
    AVM_BYTE_EN   = 4'h0;
    AVM_ADDR      = 6'd0;
    AVM_WRITEDATA = 32'd0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (EV_VALID) state_nxt = EV_ON ? W_FREQ : W_KEY;
      end
      W_FREQ: begin
        AVM_WRITE     = 1'b1;
        AVM_CS        = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = {3'b101, 1'b0, voice};
        AVM_WRITEDATA = {25'd0, note};
        if (!AVM_WAITREQUEST) state_nxt = W_AMP1;
      end
      W_AMP1: begin
        AVM_WRITE     = 1'b1;
        AVM_CS        = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = {3'b110, 1'b0, voice};
        AVM_WRITEDATA = {16'd0, amp1};
        if (!AVM_WAITREQUEST) state_nxt = W_AMP0;
      end
      W_AMP0: begin
        AVM_WRITE     = 1'b1;
        AVM_CS        = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = {3'b111, 1'b0, voice};
        AVM_WRITEDATA = {16'd0, amp0};
        if (!AVM_WAITREQUEST) state_nxt = W_KEY;
      end
      W_KEY: begin
        AVM_WRITE     = 1'b1;
        AVM_CS        = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = {3'b100, 1'b0, voice};
        AVM_WRITEDATA = {31'd0, ev_on};
        if (!AVM_WAITREQUEST) begin
`ifdef AVM_NOTE_WRITER_READBACK_EN
          state_nxt = RD_KEY;
`else
          state_nxt = IDLE;
          done      = 1'b1;
`endif
        end
      end
`ifdef AVM_NOTE_WRITER_READBACK_EN
      RD_KEY: begin
        AVM_READ    = 1'b1;
        AVM_CS      = 1'b1;
        AVM_BYTE_EN = 4'hF;
        AVM_ADDR    = {3'b100, 1'b0, voice};
        if (!AVM_WAITREQUEST) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Completed-event counter, wraps naturally at 16 bits
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  ev_cnt <= 16'd0;
    else if (done) ev_cnt <= ev_cnt + 16'd1;
  end

`ifdef AVM_NOTE_WRITER_READBACK_EN
  logic err_flag;
  logic rd_mismatch;
  logic unused_rdata;

  assign rd_mismatch  = (state == RD_KEY) && !AVM_WAITREQUEST && (AVM_READDATA[0] != ev_on);
  assign unused_rdata = ^AVM_READDATA[31:1];
  assign ERR          = err_flag;

  // Sticky error flag; a new mismatch beats a simultaneous clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)         err_flag <= 1'b0;
    else if (rd_mismatch) err_flag <= 1'b1;
    else if (CLR_ERR)     err_flag <= 1'b0;
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{CLR_ERR, AVM_READDATA};
  assign ERR           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avm_note_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_avm_note_writer
// Description : Self-checking bench for avm_note_writer. A queue of expected
//               bus transactions is built from each accepted event and
//               consumed as the slave accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avm_note_writer;

`ifdef AVM_NOTE_WRITER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EV_VALID, EV_READY, EV_ON;
  logic [1:0]  EV_VOICE;
  logic [6:0]  EV_NOTE;
  logic [15:0] EV_AMP1, EV_AMP0;
  logic [5:0]  AVM_ADDR;
  logic        AVM_WRITE, AVM_READ, AVM_CS;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA, AVM_READDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic        BUSY, ERR, CLR_ERR;
  logic [15:0] EV_COUNT;

  avm_note_writer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_ON(EV_ON), .EV_VOICE(EV_VOICE),
    .EV_NOTE(EV_NOTE), .EV_AMP1(EV_AMP1), .EV_AMP0(EV_AMP0),
    .AVM_ADDR(AVM_ADDR), .AVM_WRITE(AVM_WRITE), .AVM_READ(AVM_READ), .AVM_CS(AVM_CS),
    .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_READDATA(AVM_READDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST), .BUSY(BUSY), .EV_COUNT(EV_COUNT), .ERR(ERR),
    .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic        last;
    logic        on;
  } txn_t;

  txn_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_err   = 1'b0;
  int          cur_len   = 0;
  int          key_len   = 0;
  int          stall_pct = 0;
  int          hold_from = 0;
  int          hold_to   = 0;
  bit          rd_rand   = 1'b0;
  bit          rd_fixed  = 1'b0;
  bit          rd_bit    = 1'b0;
  bit          preload_now = 1'b0;

  assign AVM_READDATA = {31'd0, rd_bit};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // cycle counter
  always @(posedge CLK) cyc <= cyc + 1;

  // slave side: waitrequest and read data, changed just after each edge
  always @(posedge CLK) begin
    #1;
    if (cyc >= hold_from && cyc < hold_to) AVM_WAITREQUEST = 1'b1;
    else AVM_WAITREQUEST = ($urandom_range(0, 99) < stall_pct);
    rd_bit = rd_rand ? 1'($urandom_range(0, 1)) : rd_fixed;
  end

  // reference model: checks the cycle's outputs, then applies what the next edge will accept
  always @(negedge CLK) begin : monitor
    txn_t h;
    int   v;
    if (!RESET_N) begin
      q.delete();
      exp_count = 16'd0;
      exp_err   = 1'b0;
      cur_len   = 0;
    end else begin
      if (preload_now) exp_count = 16'hFFFF;
      check("ev_ready", EV_READY, q.size() == 0);
      check("busy", BUSY, q.size() != 0);
      check("ev_count", EV_COUNT, exp_count);
      check("err", ERR, exp_err);
      if (q.size() == 0) begin
        check("idle_bus", {AVM_WRITE, AVM_READ, AVM_CS, AVM_ADDR, AVM_WRITEDATA}, 41'd0);
      end else begin
        h = q[0];
        cur_len++;
        check("strobes", {AVM_WRITE, AVM_READ, AVM_CS}, h.rd ? 3'b011 : 3'b101);
        check("addr", AVM_ADDR, h.addr);
        if (!h.rd) begin
          check("wdata", AVM_WRITEDATA, h.data);
          check("byte_en", AVM_BYTE_EN, 4'hF);
        end
        if (!AVM_WAITREQUEST) begin
          void'(q.pop_front());
          if (!h.rd && h.addr[5:3] == 3'b100) key_len = cur_len;
          cur_len = 0;
          if (h.last) exp_count = exp_count + 16'd1;
`ifdef AVM_NOTE_WRITER_READBACK_EN
          if (h.rd && (AVM_READDATA[0] != h.on)) exp_err = 1'b1;
          else if (CLR_ERR) exp_err = 1'b0;
`endif
        end
`ifdef AVM_NOTE_WRITER_READBACK_EN
        else if (CLR_ERR) exp_err = 1'b0;
`endif
      end
`ifdef AVM_NOTE_WRITER_READBACK_EN
      if (q.size() == 0 && CLR_ERR) exp_err = 1'b0;
`endif
      if (EV_VALID && EV_READY) begin
        v = int'(EV_VOICE);
        if (EV_ON) begin
          q.push_back(txn_t'{addr: 6'(40 + v), data: {25'd0, EV_NOTE}, rd: 1'b0, last: 1'b0, on: EV_ON});
          q.push_back(txn_t'{addr: 6'(48 + v), data: {16'd0, EV_AMP1}, rd: 1'b0, last: 1'b0, on: EV_ON});
          q.push_back(txn_t'{addr: 6'(56 + v), data: {16'd0, EV_AMP0}, rd: 1'b0, last: 1'b0, on: EV_ON});
        end
        q.push_back(txn_t'{addr: 6'(32 + v), data: {31'd0, EV_ON}, rd: 1'b0, last: !RB, on: EV_ON});
        if (RB) q.push_back(txn_t'{addr: 6'(32 + v), data: 32'd0, rd: 1'b1, last: 1'b1, on: EV_ON});
      end
    end
  end

  // offer an event and hold it until accepted; acc = cycle index of the accepting cycle
  task automatic send_event(input bit on, input int v, input int note, input int a1, input int a0,
                            input int hold, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    EV_ON = on; EV_VOICE = 2'(v); EV_NOTE = 7'(note); EV_AMP1 = 16'(a1); EV_AMP0 = 16'(a0);
    EV_VALID = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (EV_READY && RESET_N) begin
        acc = cyc;
        hold_from = cyc + 1;
        hold_to   = cyc + 1 + hold;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      @(posedge CLK);
      #1;
    end
    EV_VALID = 1'b0;
    EV_ON = 1'($urandom); EV_VOICE = 2'($urandom); EV_NOTE = 7'($urandom);
    EV_AMP1 = 16'($urandom); EV_AMP0 = 16'($urandom);
  endtask

  // wait until EV_READY returns; lat = cycles from accepting cycle to first ready cycle
  task automatic wait_ready(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge CLK);
      #1;
      if (EV_READY) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int a, a2, lat, rel;
    RESET_N = 1'b0; EV_VALID = 1'b0; EV_ON = 1'b0; EV_VOICE = 2'd0; EV_NOTE = 7'd0;
    EV_AMP1 = 16'd0; EV_AMP0 = 16'd0; CLR_ERR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bus", {AVM_WRITE, AVM_READ, AVM_CS, AVM_ADDR, AVM_WRITEDATA}, 41'd0);
    check("rst_state", {EV_READY, BUSY, EV_COUNT, ERR}, {1'b1, 1'b0, 16'd0, 1'b0});
    @(posedge CLK);
    #2 RESET_N = 1'b1;

    // note-on v=2, no stalls
    send_event(1'b1, 2, 69, 'h1234, 'h0F00, 0, a);
    wait_ready(a, lat);
    check("non_latency", lat, 5 + int'(RB));
    check("non_count", EV_COUNT, 16'd1);

    // note-off v=3 with waitrequest held for 7 cycles
    send_event(1'b0, 3, 5, 0, 0, 7, a);
    wait_ready(a, lat);
    check("stall_key_len", key_len, 8);
    check("stall_count", EV_COUNT, 16'd2);

    // back-to-back note-ons with EV_VALID held high
    send_event(1'b1, 0, 60, 'h1111, 'h2222, 0, a);
    send_event(1'b1, 1, 64, 'h3333, 'h4444, 0, a2);
    check("b2b_gap", a2 - a, 5 + int'(RB));
    wait_ready(a2, lat);
    check("b2b_count", EV_COUNT, 16'd4);

    // reset while in W_AMP1
    send_event(1'b1, 1, 70, 'hAAAA, 'h5555, 0, a);
    @(posedge CLK);
    #2;
    check("pre_rst_amp1", {AVM_WRITE, AVM_ADDR}, {1'b1, 6'd49});
    RESET_N = 1'b0;
    #1;
    check("async_rst_bus", {AVM_WRITE, AVM_CS, AVM_ADDR, AVM_WRITEDATA}, 40'd0);
    check("async_rst_stat", {BUSY, EV_READY, EV_COUNT}, {1'b0, 1'b1, 16'd0});
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    rel = cyc;
    send_event(1'b0, 0, 0, 0, 0, 0, a);
    check("first_accept", a, rel);
    wait_ready(a, lat);
    check("post_rst_count", EV_COUNT, 16'd1);

    // readback behaviour
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    rd_fixed = 1'b0;
    send_event(1'b1, 1, 50, 'h0100, 'h0200, 0, a);
    wait_ready(a, lat);
`ifdef AVM_NOTE_WRITER_READBACK_EN
    check("rb_err_set", ERR, 1'b1);
`else
    check("rb_err_const", {ERR, AVM_READ}, 2'b00);
`endif
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    check("rb_err_clr", ERR, 1'b0);

    // randomized traffic with stalls and random read data
    stall_pct = 30;
    rd_rand   = 1'b1;
    for (int n = 0; n < 150; n++) begin
      CLR_ERR = ($urandom_range(0, 7) == 0);
      send_event(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 127),
                 $urandom_range(0, 65535), $urandom_range(0, 65535), 0, a);
      CLR_ERR = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end
    wait_ready(a, lat);
    stall_pct = 0;
    rd_rand   = 1'b0;
    rd_fixed  = 1'b0;

    // counter wrap: preload to 16'hFFFF, then one more note-off
    @(posedge CLK);
    #1;
    force dut.ev_cnt = 16'hFFFF;
    preload_now = 1'b1;
    #1 release dut.ev_cnt;
    check("preload", EV_COUNT, 16'hFFFF);
    @(posedge CLK);
    #1 preload_now = 1'b0;
    send_event(1'b0, 2, 0, 0, 0, 0, a);
    wait_ready(a, lat);
    check("wrap_count", EV_COUNT, 16'd0);

    repeat (3) @(posedge CLK);
    check("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
